ram_arb2: RTL

Two-requester round-robin arbiter sharing one 1024x16 block RAM. Requester 0 is the switch/LED front-end; requester 1 is the UART command path. The block grants at most one access per cycle and drives the RAM write and read ports from the winning requester. It returns read data with a fixed registered latency and keeps per-requester access counters for debug.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb_rr2.sv | 63 ++++++
 rtl/ram_arb2.sv | 102 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared widths and types for the two-requester RAM arbiter.
// Optional feature macro: RAM_ARB_LOCK_EN (grant locking).
package ram_arb_pkg;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 16;
  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin grant with last_grant memory; optional grant lock
// when RAM_ARB_LOCK_EN is defined. Grant is one-hot or zero, never during rst.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
`ifdef RAM_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] grant
);
  req_id_t last_grant_q, last_grant_d;
  req_id_t win;
`ifdef RAM_ARB_LOCK_EN
  logic    lock_act_q, lock_act_d;
  req_id_t lock_id_q, lock_id_d;
`endif

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (!rst) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
`ifdef RAM_ARB_LOCK_EN
      // A held lock overrides round-robin only while its owner keeps valid high.
      if (lock_act_q && valid[lock_id_q])
        grant = lock_id_q ? 2'b10 : 2'b01;
`endif
    end
    win = grant[1];
    if (|grant) last_grant_d = win;
  end

`ifdef RAM_ARB_LOCK_EN
  always_comb begin
    lock_act_d = (|grant) & lock[win];
    lock_id_d  = win;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
`ifdef RAM_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_id_q    <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
`ifdef RAM_ARB_LOCK_EN
      lock_act_q   <= lock_act_d;
      lock_id_q    <= lock_id_d;
`endif
    end
  end
endmodule

// File: rtl/ram_arb2.sv
// Two-requester arbiter in front of a 1024x16 registered-read block RAM.
// RAM_ARB_LOCK_EN adds req_lock inputs for sticky grants.
module ram_arb2 #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          req_valid,
  output logic [1:0]                          req_ready,
  input  logic [1:0]                          req_we,
  input  logic [1:0][ADDR_W-1:0]              req_addr,
  input  logic [1:0][DATA_W-1:0]              req_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [1:0]                          req_lock,
`endif
  output logic [1:0]                          rsp_valid,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic [1:0][ram_arb_pkg::CNT_W-1:0]  acc_cnt,
  output logic                                ram_wren,
  output logic [ADDR_W-1:0]                   ram_wraddr,
  output logic [DATA_W-1:0]                   ram_di,
  output logic                                ram_rden,
  output logic [ADDR_W-1:0]                   ram_rdaddr,
  input  logic [DATA_W-1:0]                   ram_do
);
  localparam int STAGES = 2;
  localparam int CNT_W  = ram_arb_pkg::CNT_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sel_t;

  logic [1:0]              grant;
  logic                    gid;
  sel_t                    sel;
  logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]         id_pipe_q, id_pipe_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0][CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

  ram_arb_rr2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
`ifdef RAM_ARB_LOCK_EN
    .lock  (req_lock),
`endif
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    gid        = grant[1];
    sel        = '{we: req_we[gid], addr: req_addr[gid], wdata: req_wdata[gid]};
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_di     = '0;
    ram_rden   = 1'b0;
    ram_rdaddr = '0;
    if (|grant) begin
      if (sel.we) begin
        ram_wren   = 1'b1;
        ram_wraddr = sel.addr;
        ram_di     = sel.wdata;
      end else begin
        ram_rden   = 1'b1;
        ram_rdaddr = sel.addr;
      end
    end
  end

  // Stage 1 is the RAM access cycle; stage 2 holds the captured ram_do.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[1], (|grant) & ~sel.we};
    id_pipe_d   = {id_pipe_q[1], gid};
    rsp_rdata_d = vld_pipe_q[1] ? ram_do : rsp_rdata_q;
    for (int k = 0; k < 2; k++)
      acc_cnt_d[k] = acc_cnt_q[k] + CNT_W'(grant[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      rsp_rdata_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      rsp_rdata_q <= rsp_rdata_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign rsp_valid = vld_pipe_q[STAGES] ? (id_pipe_q[STAGES] ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rsp_rdata_q;
  assign acc_cnt   = acc_cnt_q;
endmodule
